// File: rtl/lcd_pkg.sv
// Shared state encoding, timing defaults and output decode for the LCD panel
// power sequencer.
package lcd_pkg;

   localparam int CNT_W   = 25;
   localparam int FRAME_W = 4;
   localparam int PWM_W   = 8;

   localparam int unsigned T_VDD_CYC_DEF     = 350000;
   localparam int unsigned T_BL_FRAMES_DEF   = 4;
   localparam int unsigned T_BLOFF_CYC_DEF   = 350000;
   localparam int unsigned T_LVDSOFF_CYC_DEF = 350000;
   localparam int unsigned T_REST_CYC_DEF    = 17500000;
   localparam int unsigned LOCK_TO_CYC_DEF   = 3500000;

   typedef enum logic [3:0] {
      S_OFF       = 4'd0,
      S_WAIT_LOCK = 4'd1,
      S_VDD_ON    = 4'd2,
      S_LVDS_ON   = 4'd3,
      S_RUN       = 4'd4,
      S_BL_OFF    = 4'd5,
      S_LVDS_OFF  = 4'd6,
      S_REST      = 4'd7,
      S_FAULT     = 4'd8
   } state_e;

   typedef struct packed {
      logic vdd_en;
      logic lvds_en;
      logic bl_en;
      logic ready;
      logic fault;
   } panel_out_t;

   function automatic panel_out_t state_outputs(input state_e s);
      panel_out_t o;
      o         = '0;
      o.vdd_en  = s inside {S_VDD_ON, S_LVDS_ON, S_RUN, S_BL_OFF, S_LVDS_OFF};
      o.lvds_en = s inside {S_LVDS_ON, S_RUN, S_BL_OFF};
      o.bl_en   = (s == S_RUN);
      o.ready   = (s == S_RUN);
      o.fault   = (s == S_FAULT);
      return o;
   endfunction

endpackage

// File: rtl/lcd_bl_pwm.sv
// Backlight PWM: free-running 8-bit counter, duty level/256, level updated
// only at the period wrap so a mid-period change never produces a glitch.
module lcd_bl_pwm
   import lcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bl_en,
   input  logic [PWM_W-1:0] bl_level,
   output logic             bl_pwm
);

   logic [PWM_W-1:0] cnt_q, cnt_d;
   logic [PWM_W-1:0] level_q, level_d;

   always_comb begin
      cnt_d   = cnt_q + PWM_W'(1);
      level_d = (cnt_q == '1) ? bl_level : level_q;
   end

   // NOTE: sequential state uses non-blocking assignments only; the async
   // reset clears every flop so the output is low the instant rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         level_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   // Combinational from flops so bl_pwm is gated in the very cycle bl_en drops.
   assign bl_pwm = (cnt_q < level_q) & bl_en;

endmodule

// File: rtl/lcd_panel_seq.sv
// LCD panel power sequencer: VDD -> LVDS -> backlight on, reverse order off,
// with lock supervision and a shared down-counter for every interval.
module lcd_panel_seq
   import lcd_pkg::*;
#(
   parameter int unsigned T_VDD_CYC     = T_VDD_CYC_DEF,
   parameter int unsigned T_BL_FRAMES   = T_BL_FRAMES_DEF,
   parameter int unsigned T_BLOFF_CYC   = T_BLOFF_CYC_DEF,
   parameter int unsigned T_LVDSOFF_CYC = T_LVDSOFF_CYC_DEF,
   parameter int unsigned T_REST_CYC    = T_REST_CYC_DEF,
   parameter int unsigned LOCK_TO_CYC   = LOCK_TO_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             pll_locked,
   input  logic             sds_locked,
   input  logic             frame_start,
   input  logic [PWM_W-1:0] bl_level,
   output logic             vdd_en,
   output logic             lvds_en,
   output logic             bl_en,
   output logic             bl_pwm,
   output logic             ready,
   output logic             fault,
   output logic [3:0]       state_o
);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic                 fault_flag_q, fault_flag_d;
   panel_out_t           out_q, out_d;
   logic                 locks_ok;
   logic                 cnt_done;

   // Counter loads T-1 so a state lasts exactly T cycles including entry.
   function automatic logic [CNT_W-1:0] load_val(input state_e s);
      case (s)
         S_WAIT_LOCK: return CNT_W'(LOCK_TO_CYC - 1);
         S_VDD_ON:    return CNT_W'(T_VDD_CYC - 1);
         S_BL_OFF:    return CNT_W'(T_BLOFF_CYC - 1);
         S_LVDS_OFF:  return CNT_W'(T_LVDSOFF_CYC - 1);
         S_REST:      return CNT_W'(T_REST_CYC - 1);
         default:     return '0;
      endcase
   endfunction

   assign locks_ok = pll_locked & sds_locked;
   assign cnt_done = (cnt_q == '0);

   // NOTE: every variable written here is given a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      fault_flag_d = fault_flag_q;

      case (state_q)
         S_OFF: if (en) state_d = S_WAIT_LOCK;
         S_WAIT_LOCK: begin
            if (!en)           state_d = S_OFF;
            else if (locks_ok) state_d = S_VDD_ON;
            else if (cnt_done) state_d = S_FAULT;
         end
         S_VDD_ON: begin
            if (!locks_ok) begin
               state_d      = S_LVDS_OFF;
               fault_flag_d = 1'b1;
            end else if (!en)  state_d = S_LVDS_OFF;
            else if (cnt_done) state_d = S_LVDS_ON;
         end
         S_LVDS_ON: begin
            if (!locks_ok) begin
               state_d      = S_BL_OFF;
               fault_flag_d = 1'b1;
            end else if (!en) state_d = S_BL_OFF;
            else if (frame_start && frame_q == FRAME_W'(T_BL_FRAMES - 1))
               state_d = S_RUN;
         end
         S_RUN: begin
            if (!locks_ok) begin
               state_d      = S_BL_OFF;
               fault_flag_d = 1'b1;
            end else if (!en) state_d = S_BL_OFF;
         end
         S_BL_OFF:   if (cnt_done) state_d = S_LVDS_OFF;
         S_LVDS_OFF: if (cnt_done) state_d = S_REST;
         S_REST:     if (cnt_done) state_d = fault_flag_q ? S_FAULT : S_OFF;
         S_FAULT: begin
            if (!en) begin
               state_d      = S_OFF;
               fault_flag_d = 1'b0;
            end
         end
         default: state_d = S_OFF;
      endcase

      if (state_d != state_q) cnt_d = load_val(state_d);
      else if (!cnt_done)     cnt_d = cnt_q - CNT_W'(1);
      else                    cnt_d = cnt_q;

      frame_d = frame_q;
      if (state_d == S_LVDS_ON && state_q != S_LVDS_ON) frame_d = '0;
      else if (state_q == S_LVDS_ON && frame_start)    frame_d = frame_q + FRAME_W'(1);

      // Outputs decoded from the next state so they switch on the same edge.
      out_d = state_outputs(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_OFF;
         cnt_q        <= '0;
         frame_q      <= '0;
         fault_flag_q <= 1'b0;
         out_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         frame_q      <= frame_d;
         fault_flag_q <= fault_flag_d;
         out_q        <= out_d;
      end
   end

   assign vdd_en  = out_q.vdd_en;
   assign lvds_en = out_q.lvds_en;
   assign bl_en   = out_q.bl_en;
   assign ready   = out_q.ready;
   assign fault   = out_q.fault;
   assign state_o = state_q;

   lcd_bl_pwm u_bl_pwm (
      .clk      (clk),
      .rst_n    (rst_n),
      .bl_en    (out_q.bl_en),
      .bl_level (bl_level),
      .bl_pwm   (bl_pwm)
   );

endmodule

// File: doc/lcd_panel_seq.md
LCD_PANEL_SEQ -- requirements
Module: lcd_panel_seq

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- T_VDD_CYC, 350000: cycles from VDD on to LVDS on (10 ms at 35 MHz).
- T_BL_FRAMES, 4: whole frames with LVDS active before backlight on.
- T_BLOFF_CYC, 350000: cycles from backlight off to LVDS off.
- T_LVDSOFF_CYC, 350000: cycles from LVDS off to VDD off.
- T_REST_CYC, 17500000: minimum VDD-off time before re-power.
- LOCK_TO_CYC, 3500000: timeout waiting for PLL and serializer lock.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1: pixel clock.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: level request for panel on.
- pll_locked, in, 1: pixel PLL locked.
- sds_locked, in, 1: serializer locked.
- frame_start, in, 1: one-cycle pulse at frame start from the timing generator.
- bl_level, in, 8: backlight duty request.
- vdd_en, out, 1: panel supply enable.
- lvds_en, out, 1: the serializer word is forced to all-zero when low.
- bl_en, out, 1: backlight driver enable.
- bl_pwm, out, 1: backlight PWM.
- ready, out, 1: panel fully on.
- fault, out, 1: lock lost or timed out.
- state_o, out, 4: current state encoding.
REQ-003 Clock and reset SHALL be a single clock clk and an asynchronous active-low reset rst_n.

Function
REQ-004 The block SHALL implement a Moore FSM with states OFF, WAIT_LOCK, VDD_ON, LVDS_ON, RUN, BL_OFF, LVDS_OFF, REST and FAULT, with all outputs registered.
REQ-005 Output levels per state SHALL be as follows; all other outputs are 0.
- vdd_en = 1 in VDD_ON, LVDS_ON, RUN, BL_OFF and LVDS_OFF.
- lvds_en = 1 in LVDS_ON, RUN and BL_OFF.
- bl_en = 1 in RUN.
- ready = 1 in RUN.
- fault = 1 in FAULT.
REQ-006 OFF SHALL go to WAIT_LOCK when en=1.
REQ-007 WAIT_LOCK SHALL go to VDD_ON once pll_locked and sds_locked are both 1, and SHALL go to FAULT after LOCK_TO_CYC cycles without both locks.
REQ-008 VDD_ON SHALL go to LVDS_ON after exactly T_VDD_CYC cycles.
REQ-009 LVDS_ON SHALL count frame_start pulses and go to RUN on the T_BL_FRAMES-th pulse.
REQ-010 RUN SHALL go to BL_OFF when en=0.
REQ-011 BL_OFF SHALL go to LVDS_OFF after T_BLOFF_CYC cycles.
REQ-012 LVDS_OFF SHALL go to REST after T_LVDSOFF_CYC cycles.
REQ-013 REST SHALL go to OFF after T_REST_CYC cycles; en is ignored during REST.
REQ-014 If en drops during power-up, the block SHALL start the reverse sequence from the current stage:
- WAIT_LOCK goes to OFF.
- VDD_ON goes to LVDS_OFF, so the VDD hold is still honoured.
- LVDS_ON goes to BL_OFF.
REQ-015 Loss of either lock in VDD_ON, LVDS_ON or RUN SHALL latch a fault flag and start the reverse sequence at the matching stage (RUN goes to BL_OFF); REST then exits to FAULT instead of OFF.
REQ-016 FAULT SHALL hold all enables low and go to OFF only when en=0.
REQ-017 A single 25-bit down-counter SHALL serve all delays; it is loaded on every state entry, and an exit condition reached on the same cycle as a load takes priority.
REQ-018 When en drop and lock loss occur on the same cycle, lock loss SHALL take priority and fault SHALL be latched.
REQ-019 The frame counter SHALL be 4 bits and clear on entry to LVDS_ON; frame_start in any other state SHALL be ignored.
REQ-020 bl_pwm SHALL come from a free-running 8-bit counter and equal (cnt < level_q) AND bl_en, giving duty level/256.
- level_q samples bl_level only when cnt wraps from 255 to 0.
- level 0 gives a constant low; level 255 gives 255 high cycles per 256.
REQ-021 bl_pwm SHALL be 0 in every cycle in which bl_en=0.

Reset
REQ-022 On rst_n low, the block SHALL asynchronously force state OFF, all outputs 0, all counters 0, level_q 0 and the fault flag clear.
REQ-023 Reset mid-RUN SHALL drop all enables immediately; no timed power-down is required under reset.

Structure
REQ-024 State encodings and the default timing constants SHALL live in the shared package lcd_pkg.
REQ-025 The PWM generator SHALL be the sub-module lcd_bl_pwm; the FSM and timers SHALL stay in lcd_panel_seq.

Verification
REQ-026 The bench SHALL cover these directed scenarios with parameters 5/2/4/3/10/20:
- Power-up: locks already high, en=1, frame_start every 50 cycles -> vdd_en 1 cycle after WAIT_LOCK, lvds_en 5 cycles later, bl_en and ready on the 2nd frame_start.
- Normal power-down: en=0 in RUN -> bl_en drops next cycle, lvds_en drops 4 cycles later, vdd_en drops 3 cycles after that, OFF reached 10 cycles later.
- Lock timeout: en=1, pll_locked=0 -> FAULT after 20 cycles with fault=1 and vdd_en=0; en=0 -> OFF.
- Lock loss in RUN: sds_locked pulses low for 1 cycle -> BL_OFF, LVDS_OFF, REST, then FAULT, with intervals honoured.
- PWM duty: bl_level=0, 64, 255 -> 0, 64, 255 high cycles per 256-cycle period; bl_level changed mid-period takes effect only at the next wrap.
- Abort and reset: en=0 during VDD_ON -> LVDS_OFF with lvds_en never asserted; rst_n low in RUN -> all outputs 0 asynchronously.
